// File: rtl/mac_pkg.sv
// Shared constants and state type for the MAC operand loader.
package mac_pkg;
  localparam int MAC_IN_WIDTH  = 16;
  localparam int MAC_ACC_WIDTH = 32;
  localparam int MAC_N_TERMS   = 36;
  localparam int MAC_LAT       = 3;
  localparam int MAC_RES_DEPTH = 4;

  typedef enum logic {FILL, FULL} loader_state_t;
endpackage

// File: rtl/mac_operand_loader_result_fifo.sv
// Synchronous result FIFO with a registered head output.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [PW:0]      r_count, w_count_after_pop;
  logic             w_do_push, w_do_pop;

  assign o_full            = (r_count == (PW+1)'(DEPTH));
  assign o_empty           = (r_count == '0);
  assign w_do_pop          = i_pop & ~o_empty;
  assign w_do_push         = i_push & ~o_full;
  assign w_rd_nxt          = w_do_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_count_after_pop = r_count - {{PW{1'b0}}, w_do_pop};

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Head register tracks the entry that will be at the read pointer next cycle;
  // a push into an (effectively) empty FIFO bypasses straight to the head.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      o_head   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_after_pop + {{PW{1'b0}}, w_do_push};
      if (w_do_push && (w_count_after_pop == '0)) o_head <= i_push_data;
      else if (w_count_after_pop != '0)            o_head <= r_mem[w_rd_nxt];
    end
  end
endmodule

// File: rtl/mac_operand_loader.sv
// Assembles operand vectors for the pipelined MAC and queues its results under credit control.
module mac_operand_loader
  import mac_pkg::*;
#(
  parameter int IN_WIDTH          = MAC_IN_WIDTH,
  parameter int ACCUMULATOR_WIDTH = MAC_ACC_WIDTH,
  parameter int N_TERMS           = MAC_N_TERMS,
  parameter int MAC_LATENCY       = MAC_LAT,
  parameter int RES_DEPTH         = MAC_RES_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           a_in,
  input  logic [IN_WIDTH-1:0]           b_in,
  input  logic                          last_in,
  output logic [IN_WIDTH*N_TERMS-1:0]   mac_I_out,
  output logic [IN_WIDTH*N_TERMS-1:0]   mac_K_out,
  input  logic [ACCUMULATOR_WIDTH-1:0]  mac_res_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACCUMULATOR_WIDTH-1:0]  out_data
);
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam int CRD_W = $clog2(RES_DEPTH + 1);

  loader_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_fill_cnt;
  logic [IN_WIDTH-1:0] r_buf_a [N_TERMS];
  logic [IN_WIDTH-1:0] r_buf_b [N_TERMS];
  logic [MAC_LATENCY:1] r_vpipe;
  logic [CRD_W-1:0]    r_credits;
  logic w_accept, w_launch, w_last_slot, w_push, w_pop, w_fifo_full, w_fifo_empty;

  assign w_accept    = in_valid & in_ready;
  assign w_last_slot = (r_fill_cnt == CNT_W'(N_TERMS - 1));

  always_ff @(posedge clk) begin
    if (rst_in) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_launch    = 1'b0;
    unique case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (last_in || w_last_slot)) w_state_nxt = FULL;
      end
      FULL: begin
        if (r_credits != '0) begin
          w_launch    = 1'b1;
          w_state_nxt = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in)        r_fill_cnt <= '0;
    else if (w_launch) r_fill_cnt <= '0;
    else if (w_accept) r_fill_cnt <= r_fill_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_a[r_fill_cnt] <= a_in;
      r_buf_b[r_fill_cnt] <= b_in;
    end
  end

  // Slots at or beyond fill_cnt are masked rather than cleared, so stale data never reaches the MAC.
  always_comb begin
    mac_I_out = '0;
    mac_K_out = '0;
    for (int unsigned i = 0; i < N_TERMS; i++) begin
      if (CNT_W'(i) < r_fill_cnt) begin
        mac_I_out[i*IN_WIDTH +: IN_WIDTH] = r_buf_a[i];
        mac_K_out[i*IN_WIDTH +: IN_WIDTH] = r_buf_b[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[1] <= w_launch;
      for (int unsigned k = 2; k <= MAC_LATENCY; k++) r_vpipe[k] <= r_vpipe[k-1];
    end
  end

  assign w_push    = r_vpipe[MAC_LATENCY] & ~w_fifo_full;
  assign out_valid = ~w_fifo_empty;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst_in)
      r_credits <= CRD_W'(RES_DEPTH);
    else if (w_launch && !w_pop)
      r_credits <= r_credits - 1'b1;
    else if (!w_launch && w_pop && (r_credits != CRD_W'(RES_DEPTH)))
      r_credits <= r_credits + 1'b1;
  end

  result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (ACCUMULATOR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_in      (rst_in),
    .i_push      (w_push),
    .i_push_data (mac_res_in),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (out_data)
  );
endmodule

// File: tb/tb_mac_operand_loader.sv
// Randomized and directed bench for mac_operand_loader against a vector-level dot-product model.
module tb_mac_operand_loader;
  localparam int IW  = 16;
  localparam int AW  = 32;
  localparam int NT  = 36;
  localparam int LAT = 3;
  localparam int RD  = 4;
  localparam int VW  = IW * NT;

  logic          clk = 1'b0;
  logic          rst_in, in_valid, in_ready, last_in, out_valid, out_ready;
  logic [IW-1:0] a_in, b_in;
  logic [VW-1:0] mac_I_out, mac_K_out;
  logic [AW-1:0] mac_res_in, out_data;

  always #5 clk = ~clk;

  mac_operand_loader #(
    .IN_WIDTH          (IW),
    .ACCUMULATOR_WIDTH (AW),
    .N_TERMS           (NT),
    .MAC_LATENCY       (LAT),
    .RES_DEPTH         (RD)
  ) dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .last_in    (last_in),
    .mac_I_out  (mac_I_out),
    .mac_K_out  (mac_K_out),
    .mac_res_in (mac_res_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pipelined MAC stand-in: computes every cycle, result appears LAT cycles after the operands.
  function automatic logic [AW-1:0] dot(input logic [VW-1:0] iv, input logic [VW-1:0] kv);
    int s, pa, pb;
    s = 0;
    for (int i = 0; i < NT; i++) begin
      pa = int'($signed(iv[i*IW +: IW]));
      pb = int'($signed(kv[i*IW +: IW]));
      s += pa * pb;
    end
    return AW'(s);
  endfunction

  logic [AW-1:0] mac_p [LAT];
  always @(posedge clk) begin
    mac_p[0] <= dot(mac_I_out, mac_K_out);
    for (int k = 1; k < LAT; k++) mac_p[k] <= mac_p[k-1];
  end
  assign mac_res_in = mac_p[LAT-1];

  // Reference model: accumulate accepted pairs, queue the expected result per completed vector.
  int            cyc = 0;
  longint        cur_sum = 0;
  int            cur_n = 0;
  logic [AW-1:0] exp_q [$];
  int            last_accept_cyc = 0, rise_cyc = 0, n_pops = 0, overflow_cnt = 0;
  logic [AW-1:0] last_pop = '0;
  logic          prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_in) begin
      if (in_valid && in_ready) begin
        cur_sum += longint'($signed(a_in)) * longint'($signed(b_in));
        cur_n++;
        last_accept_cyc = cyc;
        if (cur_n == NT || last_in) begin
          exp_q.push_back(cur_sum[AW-1:0]);
          cur_sum = 0;
          cur_n   = 0;
        end
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stale_result", out_valid, 1'b0);
        else                   check("out_data", out_data, exp_q.pop_front());
        last_pop = out_data;
        n_pops++;
      end
      if (dut.w_fifo_full && dut.r_vpipe[LAT]) overflow_cnt++;
    end
    prev_valid = out_valid;
  end

  task automatic send_pair(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic last);
    int waited = 0;
    in_valid = 1'b1; a_in = a; b_in = b; last_in = last;
    @(negedge clk);
    while (!in_ready && waited < 3000) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; last_in = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && t < budget) begin
      tick(1);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic          drv_done, rnd_stop;
  logic [VW-1:0] ev_a, ev_b;
  logic [AW-1:0] e_val;
  int            base_pops, exp_vecs;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; last_in = 1'b0; out_ready = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_mac_I", mac_I_out, '0);
    check("rst_mac_K", mac_K_out, '0);
    @(posedge clk); #1;
    rst_in = 1'b0;

    // a = 1..36, b = 1
    out_ready = 1'b1;
    for (int i = 1; i <= NT; i++) send_pair(IW'(i), IW'(1), 1'b0);
    tick(10);
    check("sum_1_to_36", last_pop, AW'(666));
    check("latency", rise_cyc - last_accept_cyc, 5);

    // a = -2, b = 3
    for (int i = 0; i < NT; i++) send_pair(IW'(-2), IW'(3), 1'b0);
    tick(10);
    e_val = AW'(-216);
    check("neg_product", last_pop, e_val);

    // short vector of 5 with zero padding
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_pair(IW'(10), IW'(2), i == 4);
    @(negedge clk);
    ev_a = '0; ev_b = '0;
    for (int i = 0; i < 5; i++) begin
      ev_a[i*IW +: IW] = IW'(10);
      ev_b[i*IW +: IW] = IW'(2);
    end
    check("short_full_ready", in_ready, 1'b0);
    check("short_mac_I", mac_I_out, ev_a);
    check("short_mac_K", mac_K_out, ev_b);
    @(negedge clk);
    check("fill_mask_zero", mac_I_out, '0);
    out_ready = 1'b1;
    tick(10);
    check("short_sum", last_pop, AW'(100));

    // backpressure: 6 vectors, no draining
    out_ready = 1'b0;
    tick(1);
    base_pops = n_pops;
    drv_done  = 1'b0;
    fork
      begin
        for (int v = 0; v < 6; v++)
          for (int i = 0; i < NT; i++)
            send_pair(IW'($urandom), IW'($urandom), 1'b0);
        drv_done = 1'b1;
      end
    join_none
    tick(230);
    @(negedge clk);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_no_pops", n_pops - base_pops, 0);
    check("stall_queued", exp_q.size(), 5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("credit_launch_cycle", in_ready, 1'b0);
    @(negedge clk);
    check("credit_refill", in_ready, 1'b1);
    tick(60);
    out_ready = 1'b1;
    for (int t = 0; t < 2000 && !drv_done; t++) tick(1);
    check("bp_driver_done", drv_done, 1'b1);
    drain(200);
    check("bp_pop_count", n_pops - base_pops, 6);

    // reset with results in flight
    out_ready = 1'b0;
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < 3; i++) send_pair(IW'($urandom), IW'($urandom), i == 2);
    for (int i = 0; i < 14; i++) send_pair(IW'($urandom), IW'($urandom), 1'b0);
    rst_in = 1'b1;
    exp_q.delete();
    cur_sum = 0;
    cur_n   = 0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_mac_I", mac_I_out, '0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    tick(10);
    check("post_rst_no_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    tick(10);

    // randomized vectors with random gaps and random output backpressure
    base_pops = n_pops;
    exp_vecs  = 14;
    drv_done  = 1'b0;
    rnd_stop  = 1'b0;
    fork
      begin
        while (!rnd_stop) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
      begin
        for (int v = 0; v < exp_vecs; v++) begin
          int len;
          logic lst;
          len = $urandom_range(1, NT);
          for (int i = 0; i < len; i++) begin
            lst = (i == len - 1) && ((len < NT) || ($urandom_range(0, 1) == 1));
            send_pair(IW'($urandom), IW'($urandom), lst);
            if ($urandom_range(0, 4) == 0) tick($urandom_range(1, 3));
          end
        end
        drv_done = 1'b1;
      end
    join_none
    for (int t = 0; t < 6000 && !drv_done; t++) tick(1);
    check("rnd_driver_done", drv_done, 1'b1);
    rnd_stop = 1'b1;
    tick(2);
    drain(300);
    check("rnd_pop_count", n_pops - base_pops, exp_vecs);
    check("no_overflow", overflow_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
